syst_apb_nxn: RTL and testbench
===============================

// Module: syst_apb_nxn
// PURPOSE
//  APB slave wrapping a parametrised N x N weight-stationary systolic array for
//  unsigned matrix multiply C = A x B. Weights (B) are loaded per column, rows
//  of A are streamed in, and rows of C are queued in a result FIFO that is
//  drained over APB. Adds saturation/wrap mode, result buffering, status/error
//  flags and a ready-pending output.
// PARAMETERS
//  N        4   array dimension; N*DW <= 32 and N*OUT_W <= 32
//  DW       8   operand lane width (unsigned)
//  OUT_W    8   result lane width returned over APB
//  RES_DEPTH 8  result FIFO depth in rows (power of 2, >= 2)
// PORTS
//  p_clk_i    in   1   clock; all state updates on rising edge
//  p_rst_i    in   1   asynchronous, active-high reset
//  p_dat_i    in   32  APB write data
//  p_dat_o    out  32  APB read data (registered, held between reads)
//  p_enable_i in   1   APB enable (access phase)
//  p_sel_i    in   1   APB select
//  p_we_i     in   1   APB write(1)/read(0)
//  p_adr_i    in   32  APB byte address
//  p_ready    out  1   APB ready
//  res_irq_o  out  1   high while result FIFO non-empty
// BEHAVIOUR
//  Reset: p_dat_o=0, p_ready=0, res_irq_o=0; weights, pipeline, FIFO, flags,
//   CTRL all 0.
//  Register map (lane k = bits [k*W +: W]):
//   0x00 ROW_IN  W: lane k = A[i][k]; pushes one row into the array
//   0x04 RES_OUT R: pops one row; lane j = C[i][j]
//   0x08+4*j WCOL_j W (j<N): lane k = B[k][j]
//   0x40 CTRL R/W: b0 SAT (1=saturate, 0=truncate); b1 CLR (write-1, self-clear)
//   0x44 STATUS R: b0 busy, b1 empty, b2 full, b3 ovf, b4 udf, b[15:8] count
//   other addresses: write ignored, read returns 0, zero wait states.
//  APB: setup = sel&!enable, access = sel&enable; a transfer completes on the
//   edge where sel&enable&p_ready. p_ready is 0 outside access phase.
//  p_ready =1 in access phase, except WCOL write while busy: held 0 until the
//   pipeline drains (busy=0), then 1; weight written on the completing edge.
//  Reads: p_dat_o is loaded (and RES_OUT popped) on the edge ending setup;
//   p_dat_o holds its value until the next read.
//  ROW_IN write is accepted on the completing edge; row enters the input skew.
//   The result row is written to FIFO exactly 2*N cycles later. Rows may be
//   issued back to back (one per APB transfer); ordering is preserved.
//  busy = any row in skew/array not yet written to FIFO.
//  Arithmetic: products DW x DW unsigned, accumulator width 2*DW+clog2(N).
//   SAT=1: lane = min(acc, 2^OUT_W-1); SAT=0: lane = acc[OUT_W-1:0].
//   SAT is sampled per row at ROW_IN acceptance.
//  FIFO full: ROW_IN is accepted only if count + in-flight rows < RES_DEPTH;
//   otherwise row dropped, ovf sticky set, p_ready still 1.
//  RES_OUT read when empty: p_dat_o=0, udf sticky set, FIFO unchanged.
//  CLR: flushes pipeline and FIFO, clears ovf/udf; weights and SAT kept.
//  Async reset mid-operation: everything returns to reset values at once;
//   in-flight rows are lost.
//  res_irq_o = !empty, registered alongside FIFO count.
// TESTING
//  1 Load B cols from B=[1 4 5 6;5 4 8 0;1 6 2 7;2 3 1 0], push A rows
//   [7 4 4 3],[1 5 5 1],[7 0 2 4],[1 2 4 2] -> RES_OUT reads 0x464E4D25,
//   0x29383921, then C rows 3,4 = 17 52 43 56 and 19 42 31 34.
//  2 All A,B lanes = 255, SAT=1 -> every lane 255; SAT=0 -> every lane 4.
//  3 Push RES_DEPTH+1 rows without reading -> last row dropped, STATUS ovf=1,
//   full=1; reading RES_DEPTH times returns rows in push order.
//  4 Read RES_OUT on empty FIFO -> p_dat_o=0, udf=1; CLR write -> ovf=udf=0.
//  5 WCOL write immediately after ROW_IN -> p_ready low until busy=0, then
//   next row uses new weights, in-flight row uses old weights.
//  6 Assert p_rst_i while rows in flight -> p_ready=0, res_irq_o=0,
//   STATUS reads 0x0002 after release.

Source files
------------

// File: rtl/syst_apb_nxn.sv
// APB-mapped N x N weight-stationary systolic multiplier (C = A x B, unsigned).
// Rows of A go through N accumulating PE stages and N de-skew stages, then land in a result FIFO.
module syst_apb_nxn #(
  parameter int N         = 4,
  parameter int DW        = 8,
  parameter int OUT_W     = 8,
  parameter int RES_DEPTH = 8
) (
  input  logic        p_clk_i,
  input  logic        p_rst_i,
  input  logic [31:0] p_dat_i,
  output logic [31:0] p_dat_o,
  input  logic        p_enable_i,
  input  logic        p_sel_i,
  input  logic        p_we_i,
  input  logic [31:0] p_adr_i,
  output logic        p_ready,
  output logic        res_irq_o
);
  localparam int ACC_W = 2*DW + $clog2(N);
  localparam int S     = 2*N;
  localparam int AW    = $clog2(RES_DEPTH);
  localparam int CW    = AW + 1;
  localparam int RW    = N*OUT_W;
  localparam int AIW   = N*DW;
  localparam int JW    = $clog2(N);

  logic [DW-1:0]    w_reg [N][N];        // [k][j] = B[k][j]
  logic [AIW-1:0]   a_pipe [N-1];
  logic [ACC_W-1:0] acc_pipe [S][N];
  logic [ACC_W-1:0] acc_d [S][N];
  logic [S-1:0]     vld_pipe, sat_pipe;
  logic [RW-1:0]    mem [RES_DEPTH];
  logic [RW-1:0]    res_row;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count, count_next;
  logic             sat_reg, ovf_reg, udf_reg;
  logic [31:0]      occ, rdata;
  logic [JW-1:0]    wcol_idx;
  logic is_row, is_res, is_ctrl, is_stat, is_wcol;
  logic busy, empty, full, wr, row_wr, admit, clr, rd_setup, pop, push;

  assign is_row   = (p_adr_i == 32'h00);
  assign is_res   = (p_adr_i == 32'h04);
  assign is_ctrl  = (p_adr_i == 32'h40);
  assign is_stat  = (p_adr_i == 32'h44);
  assign is_wcol  = (p_adr_i >= 32'h08) && (p_adr_i < 32'(8 + 4*N)) && (p_adr_i[1:0] == 2'b00);
  assign wcol_idx = p_adr_i[2 +: JW] - JW'(2);

  assign busy  = |vld_pipe;
  assign empty = (count == '0);
  assign full  = (count == CW'(RES_DEPTH));

  // Weight writes stall while any row still depends on the current weights.
  assign p_ready  = p_sel_i & p_enable_i & ~p_rst_i & ~(p_we_i & is_wcol & busy);
  assign wr       = p_ready & p_we_i;
  assign row_wr   = wr & is_row;
  assign admit    = row_wr & (occ < 32'(RES_DEPTH));
  assign clr      = wr & is_ctrl & p_dat_i[1];
  assign rd_setup = p_sel_i & ~p_enable_i & ~p_we_i;
  assign pop      = rd_setup & is_res & ~empty;
  assign push     = vld_pipe[S-1];

  always_comb begin
    occ = 32'(count);
    for (int s = 0; s < S; s++) occ = occ + 32'(vld_pipe[s]);
  end

  always_comb begin
    count_next = count;
    if (clr) begin
      count_next = '0;
    end else begin
      if (push) count_next = count_next + CW'(1);
      if (pop)  count_next = count_next - CW'(1);
    end
  end

  always_comb begin
    rdata = '0;
    if (is_res && !empty) rdata = 32'(mem[rd_ptr]);
    else if (is_ctrl)     rdata = {31'b0, sat_reg};
    else if (is_stat)     rdata = {16'b0, 8'(count), 3'b0, udf_reg, ovf_reg, full, empty, busy};
  end

  genvar gi, gj;
  generate
    for (gi = 0; gi < S; gi++) begin : g_stage
      for (gj = 0; gj < N; gj++) begin : g_pe
        if (gi == 0) begin : g_first
          assign acc_d[gi][gj] = ACC_W'(p_dat_i[0 +: DW]) * ACC_W'(w_reg[0][gj]);
        end else if (gi < N) begin : g_mac
          assign acc_d[gi][gj] = acc_pipe[gi-1][gj]
                               + ACC_W'(a_pipe[gi-1][gi*DW +: DW]) * ACC_W'(w_reg[gi][gj]);
        end else begin : g_skew
          assign acc_d[gi][gj] = acc_pipe[gi-1][gj];
        end
      end
    end
    for (gj = 0; gj < N; gj++) begin : g_lane
      assign res_row[gj*OUT_W +: OUT_W] =
        (sat_pipe[S-1] && (acc_pipe[S-1][gj] > ACC_W'({OUT_W{1'b1}}))) ?
        {OUT_W{1'b1}} : acc_pipe[S-1][gj][OUT_W-1:0];
    end
  endgenerate

  always_ff @(posedge p_clk_i or posedge p_rst_i) begin
    if (p_rst_i) begin
      vld_pipe <= '0;
      sat_pipe <= '0;
      for (int s = 0; s < N-1; s++) a_pipe[s] <= '0;
      for (int s = 0; s < S; s++)
        for (int j = 0; j < N; j++) acc_pipe[s][j] <= '0;
    end else begin
      vld_pipe <= clr ? '0 : {vld_pipe[S-2:0], admit};
      sat_pipe <= {sat_pipe[S-2:0], sat_reg};
      a_pipe[0] <= p_dat_i[AIW-1:0];
      for (int s = 1; s < N-1; s++) a_pipe[s] <= a_pipe[s-1];
      for (int s = 0; s < S; s++)
        for (int j = 0; j < N; j++) acc_pipe[s][j] <= acc_d[s][j];
    end
  end

  always_ff @(posedge p_clk_i) begin
    if (push && !clr) mem[wr_ptr] <= res_row;
  end

  always_ff @(posedge p_clk_i or posedge p_rst_i) begin
    if (p_rst_i) begin
      for (int k = 0; k < N; k++)
        for (int j = 0; j < N; j++) w_reg[k][j] <= '0;
      p_dat_o   <= '0;
      sat_reg   <= 1'b0;
      ovf_reg   <= 1'b0;
      udf_reg   <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      res_irq_o <= 1'b0;
    end else begin
      if (wr && is_ctrl) sat_reg <= p_dat_i[0];
      if (wr && is_wcol)
        for (int k = 0; k < N; k++) w_reg[k][wcol_idx] <= p_dat_i[k*DW +: DW];
      if (rd_setup) p_dat_o <= rdata;
      if (clr) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        ovf_reg <= 1'b0;
        udf_reg <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        if (row_wr && !admit) ovf_reg <= 1'b1;
        if (rd_setup && is_res && empty) udf_reg <= 1'b1;
      end
      count     <= count_next;
      res_irq_o <= (count_next != '0);
    end
  end
endmodule

// File: tb/tb_syst_apb_nxn.sv
// Testbench for syst_apb_nxn: APB transfers, result-row scoreboard, latency/stall/reset corners.
module tb_syst_apb_nxn;
  localparam int N = 4;
  localparam int DEPTH = 8;

  logic        clk = 0, rst = 1;
  logic [31:0] wdat = 0, rdat, adr = 0;
  logic        en = 0, sel = 0, we = 0, ready, irq;

  int checks = 0, errors = 0;
  logic [7:0]  bw [N][N];
  logic        sat_m = 0;
  logic [31:0] sb[$];

  typedef struct { logic [31:0] a; logic [31:0] exp; } vec_t;
  vec_t tv[4];

  syst_apb_nxn #(.N(N), .DW(8), .OUT_W(8), .RES_DEPTH(DEPTH)) dut (
    .p_clk_i(clk), .p_rst_i(rst), .p_dat_i(wdat), .p_dat_o(rdat),
    .p_enable_i(en), .p_sel_i(sel), .p_we_i(we), .p_adr_i(adr),
    .p_ready(ready), .res_irq_o(irq));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] a, input logic sat);
    logic [31:0] r;
    r = 0;
    for (int j = 0; j < N; j++) begin
      int acc;
      acc = 0;
      for (int k = 0; k < N; k++) acc = acc + int'(a[k*8 +: 8]) * int'(bw[k][j]);
      if (sat && acc > 255) acc = 255;
      r[j*8 +: 8] = acc[7:0];
    end
    return r;
  endfunction

  task automatic apb_write(input logic [31:0] a, input logic [31:0] d, output int waits);
    @(negedge clk); sel = 1; en = 0; we = 1; adr = a; wdat = d;
    @(negedge clk); en = 1; waits = 0; #1;
    while (!ready && waits < 200) begin @(negedge clk); #1; waits++; end
    chk("apb_wr_ready", 32'(ready), 32'd1);
    @(posedge clk); #1; sel = 0; en = 0; we = 0;
    $display("APB WR adr=%h dat=%h waits=%0d", a, d, waits);
  endtask

  task automatic apb_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk); sel = 1; en = 0; we = 0; adr = a;
    @(negedge clk); en = 1; #1;
    chk("apb_rd_ready", 32'(ready), 32'd1);
    @(posedge clk); #1; sel = 0; en = 0;
    d = rdat;
    $display("APB RD adr=%h dat=%h", a, d);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    int w;
    apb_write(a, d, w);
  endtask

  task automatic set_ctrl(input logic [31:0] d);
    wr(32'h40, d);
    sat_m = d[0];
  endtask

  task automatic write_wcol(input int j, input logic [31:0] d, output int waits);
    apb_write(32'(8 + 4*j), d, waits);
    for (int k = 0; k < N; k++) bw[k][j] = d[k*8 +: 8];
  endtask

  task automatic load_b(input logic [31:0] c0, c1, c2, c3);
    int w;
    write_wcol(0, c0, w); write_wcol(1, c1, w); write_wcol(2, c2, w); write_wcol(3, c3, w);
  endtask

  // Expectation is queued only when the model FIFO (queued + in flight) has room.
  task automatic push_row(input logic [31:0] a, input logic [31:0] exp);
    if (sb.size() < DEPTH) sb.push_back(exp);
    wr(32'h00, a);
  endtask

  task automatic read_res(input string name);
    logic [31:0] d, e;
    apb_read(32'h04, d);
    e = (sb.size() == 0) ? 32'h0 : sb.pop_front();
    chk(name, d, e);
  endtask

  task automatic status(input string name, input logic [31:0] exp);
    logic [31:0] d;
    apb_read(32'h44, d);
    chk(name, d, exp);
  endtask

  initial begin
    logic [31:0] d, r;
    int w;
    for (int k = 0; k < N; k++) for (int j = 0; j < N; j++) bw[k][j] = 0;
    tv[0] = '{32'h03040407, 32'h464E4D25};
    tv[1] = '{32'h01050501, 32'h29383921};
    tv[2] = '{32'h04020007, 32'h382B3411};
    tv[3] = '{32'h02040201, 32'h221F2A13};

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_dat", rdat, 32'h0);
    chk("rst_ready", 32'(ready), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    rst = 0;
    status("rst_status", 32'h0002);
    apb_read(32'h40, d); chk("rst_ctrl", d, 32'h0);
    apb_read(32'h80, d); chk("unmapped_rd", d, 32'h0);

    // table-driven matrix multiply
    load_b(32'h02010501, 32'h03060404, 32'h01020805, 32'h00070006);
    set_ctrl(32'h1);
    for (int i = 0; i < 4; i++) push_row(tv[i].a, tv[i].exp);
    repeat (12) @(negedge clk);
    for (int i = 0; i < 4; i++) read_res($sformatf("mm_row%0d", i));

    // saturate vs truncate with all-ones operands
    load_b(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
    set_ctrl(32'h1); push_row(32'hFFFFFFFF, 32'hFFFFFFFF);
    set_ctrl(32'h0); push_row(32'hFFFFFFFF, 32'h04040404);
    repeat (12) @(negedge clk);
    read_res("sat_on"); read_res("sat_off");

    // weight write stalls behind an in-flight row
    load_b(32'h02010501, 32'h03060404, 32'h01020805, 32'h00070006);
    set_ctrl(32'h1);
    r = 32'h03040407;
    push_row(r, model(r, sat_m));
    write_wcol(0, 32'h01010101, w);
    chk("wcol_stall", 32'(w), 32'(2*N-1));
    push_row(r, model(r, sat_m));
    repeat (12) @(negedge clk);
    read_res("old_weights"); read_res("new_weights");

    // exact 2*N result latency, seen on the irq flag
    push_row(32'h01020304, model(32'h01020304, sat_m));
    repeat (2*N-1) @(posedge clk);
    #1 chk("lat_before", 32'(irq), 32'h0);
    @(posedge clk);
    #1 chk("lat_at", 32'(irq), 32'h1);
    read_res("lat_row");

    // overflow: DEPTH+1 rows, last dropped, order preserved
    set_ctrl(32'h0);
    for (int i = 0; i <= DEPTH; i++) begin
      r = $urandom;
      push_row(r, model(r, sat_m));
    end
    repeat (12) @(negedge clk);
    status("ovf_status", 32'h080C);
    for (int i = 0; i < DEPTH; i++) read_res($sformatf("fifo_row%0d", i));

    // underflow, then CLR
    read_res("udf_read");
    status("udf_status", 32'h001A);
    set_ctrl(32'h2);
    status("clr_status", 32'h0002);

    // async reset with rows in flight
    set_ctrl(32'h1);
    push_row(32'h01010101, model(32'h01010101, sat_m));
    w = 0;
    while (!irq && w < 30) begin @(negedge clk); w++; end
    chk("irq_up", 32'(irq), 32'h1);
    push_row(32'h02020202, model(32'h02020202, sat_m));
    @(negedge clk);
    rst = 1; sel = 1; en = 1; we = 0; adr = 32'h44;
    #1;
    chk("rst_mid_ready", 32'(ready), 32'h0);
    chk("rst_mid_irq", 32'(irq), 32'h0);
    @(negedge clk);
    rst = 0; sel = 0; en = 0;
    sb.delete();
    status("post_rst_status", 32'h0002);
    repeat (20) @(negedge clk);
    status("post_rst_drain", 32'h0002);
    apb_read(32'h40, d); chk("post_rst_ctrl", d, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
